seg_calc_sched: RTL

Sequencing controller and two-way arbiter for the shared 3-bit add/multiply datapath and its two-digit seven-segment display. It accepts operation requests from two input panels, grants one at a time round-robin, and computes the add or multiply result. It converts that result to tens/ones BCD by iterative subtraction, with no divider, and holds the digits on the display decoders for a programmable time before serving the next request.

---
 rtl/seg_calc_pkg.sv | 19 +
 rtl/seg_calc_rr_arb.sv | 37 +++
 rtl/seg_calc_sched.sv | 127 ++++++++++++
 3 files changed

// File: rtl/seg_calc_pkg.sv
// Shared types and constants for the seg_calc add/multiply display sequencer.
// Optional leading-zero blanking is enabled by defining SEG_CALC_BLANK_EN.
package seg_calc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        CONVERT = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    localparam int DEC_STEP = 10;

endpackage

// File: rtl/seg_calc_rr_arb.sv
// Two-way round-robin arbiter; the pointer names the favoured requester and
// moves to the other requester whenever a grant is taken.
module seg_calc_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       winner
);

    logic ptr;

    // Pick the winner: a sole requester always wins, a tie goes to the pointer.
    always_comb begin
        winner = ptr;
        grant  = 2'b00;
        if (req == 2'b01) begin
            winner = 1'b0;
        end else if (req == 2'b10) begin
            winner = 1'b1;
        end
        if (|req) begin
            grant[winner] = 1'b1;
        end
    end

    // Favour the requester that was not granted last.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance && (|req)) begin
            ptr <= ~winner;
        end
    end

endmodule

// File: rtl/seg_calc_sched.sv
// Arbitrated add/multiply sequencer with iterative BCD conversion and display hold.
// Define SEG_CALC_BLANK_EN to blank the tens digit for results below ten.
module seg_calc_sched
    import seg_calc_pkg::*;
#(
    parameter int OPW         = 3,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req,
    input  logic [OPW-1:0] op_a0,
    input  logic [OPW-1:0] op_b0,
    input  logic           mode0,
    input  logic [OPW-1:0] op_a1,
    input  logic [OPW-1:0] op_b1,
    input  logic           mode1,
    output logic [1:0]     gnt,
    output logic           busy,
    output logic           owner,
    output logic [3:0]     tens,
    output logic [3:0]     ones,
    output logic           disp_valid,
    output logic           done
);

    localparam int RW  = 2 * OPW;
    localparam int HCW = $clog2(HOLD_CYCLES + 1);

    state_t          state;
    logic [OPW-1:0]  op_a;
    logic [OPW-1:0]  op_b;
    logic            mode;
    logic [RW-1:0]   rem;
    logic [3:0]      count;
    logic [HCW-1:0]  hold_cnt;

    logic [1:0]      arb_grant;
    logic            arb_winner;
    logic            arb_take;
    logic [RW-1:0]   sum;
    logic [RW-1:0]   prod;
    logic [3:0]      tens_next;

    assign arb_take = (state == IDLE);
    assign busy     = (state != IDLE);

    seg_calc_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (arb_take),
        .grant   (arb_grant),
        .winner  (arb_winner)
    );

    assign sum  = RW'(op_a) + RW'(op_b);
    assign prod = RW'(op_a) * RW'(op_b);

`ifdef SEG_CALC_BLANK_EN
    assign tens_next = (count == 4'd0) ? BCD_BLANK : count;
`else
    assign tens_next = count;
`endif

    // Main sequencer: grant, compute, divide-by-subtraction, then hold digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= 2'b00;
            owner      <= 1'b0;
            tens       <= 4'd0;
            ones       <= 4'd0;
            disp_valid <= 1'b0;
            done       <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            mode       <= OP_ADD;
            rem        <= '0;
            count      <= 4'd0;
            hold_cnt   <= '0;
        end else begin
            gnt  <= 2'b00;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        gnt        <= arb_grant;
                        owner      <= arb_winner;
                        op_a       <= arb_winner ? op_a1 : op_a0;
                        op_b       <= arb_winner ? op_b1 : op_b0;
                        mode       <= arb_winner ? mode1 : mode0;
                        disp_valid <= 1'b0;
                        state      <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    rem   <= (mode == OP_MUL) ? prod : sum;
                    count <= 4'd0;
                    state <= CONVERT;
                end
                CONVERT: begin
                    if (int'(rem) >= DEC_STEP) begin
                        rem   <= rem - RW'(DEC_STEP);
                        count <= count + 4'd1;
                    end else begin
                        tens       <= tens_next;
                        ones       <= 4'(rem);
                        done       <= 1'b1;
                        disp_valid <= 1'b1;
                        hold_cnt   <= HCW'(1);
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == HCW'(HOLD_CYCLES)) begin
                        hold_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HCW'(1);
                    end
                end
            endcase
        end
    end

endmodule
